// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction-memory access arbiter.
// Optional address checking is enabled with the IMEM_ADDR_CHECK_EN macro.
package imem_arb_pkg;

    typedef enum logic {ST_BOOT, ST_RUN} arb_state_t;

    typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_LOAD} rd_owner_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // True when a byte address is not word aligned or lies beyond the RAM.
    function automatic logic addr_misfit(input logic [31:0] addr, input int unsigned aw);
        return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != 32'd0);
    endfunction

endpackage

// File: rtl/imem_arb_starve_ctr.sv
// Saturating count of consecutive loader losses while the core is fetching.
// at_limit tells the arbiter to hand the loader one slot.
module imem_arb_starve_ctr #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] cnt_p1;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt_p1 <= '0;
        end else if (inc && (cnt_p1 != LIMIT)) begin
            cnt_p1 <= cnt_p1 + 1'b1;
        end
    end

    assign at_limit = (cnt_p1 == LIMIT);

endmodule

// File: rtl/imem_access_arbiter.sv
// Shares one synchronous-read instruction RAM between core fetch and a boot/debug loader.
// Define IMEM_ADDR_CHECK_EN to trap misaligned/out-of-range addresses and add fault outputs.
module imem_access_arbiter
    import imem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 10,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  boot_done,
    input  logic                  fetch_req,
    input  logic [31:0]           fetch_addr,
    output logic                  fetch_gnt,
    output logic                  fetch_rvalid,
    output logic [31:0]           fetch_rdata,
    output logic                  core_stall,
    input  logic                  load_req,
    input  logic                  load_we,
    input  logic [31:0]           load_addr,
    input  logic [31:0]           load_wdata,
    output logic                  load_gnt,
    output logic                  load_rvalid,
    output logic [31:0]           load_rdata,
`ifdef IMEM_ADDR_CHECK_EN
    output logic                  fetch_fault,
    output logic                  load_fault,
`endif
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    arb_state_t state_p1, state_nxt;
    rd_owner_t  rd_owner_p1, rd_owner_nxt;
    logic       starve_at_limit;
    logic       fetch_bad, load_bad;
    logic       fetch_nop_p1, load_nop_p1, load_flt_p1;
    logic [31:0] fetch_hold_p1, load_hold_p1;

    // Address bits outside the word index only matter when checking is enabled.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{fetch_addr[31:ADDR_WIDTH+2], fetch_addr[1:0],
                                load_addr[31:ADDR_WIDTH+2], load_addr[1:0]};

`ifdef IMEM_ADDR_CHECK_EN
    assign fetch_bad = addr_misfit(fetch_addr, ADDR_WIDTH);
    assign load_bad  = addr_misfit(load_addr, ADDR_WIDTH);
`else
    assign fetch_bad = 1'b0;
    assign load_bad  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_p1 <= ST_BOOT;
        end else begin
            state_p1 <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_p1;
        if ((state_p1 == ST_BOOT) && boot_done) begin
            state_nxt = ST_RUN;
        end
    end

    // Request stage (p0): grant decision is purely combinational from requests and state.
    always_comb begin
        fetch_gnt = 1'b0;
        load_gnt  = 1'b0;
        if (!reset) begin
            case (state_p1)
                ST_BOOT: load_gnt = load_req;
                ST_RUN: begin
                    if (load_req && (!fetch_req || starve_at_limit)) begin
                        load_gnt = 1'b1;
                    end else begin
                        fetch_gnt = fetch_req;
                    end
                end
                default: ;
            endcase
        end
        core_stall = reset || (state_p1 == ST_BOOT) || (fetch_req && !fetch_gnt);
    end

    imem_arb_starve_ctr #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk     (clk),
        .reset   (reset),
        .inc     ((state_p1 == ST_RUN) && load_req && fetch_req && fetch_gnt),
        .clr     (load_gnt || !load_req),
        .at_limit(starve_at_limit)
    );

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (fetch_gnt) begin
            mem_en   = !fetch_bad;
            mem_addr = fetch_addr[ADDR_WIDTH+1:2];
        end else if (load_gnt) begin
            mem_en   = !load_bad;
            mem_we   = load_we && !load_bad;
            mem_addr = load_addr[ADDR_WIDTH+1:2];
            if (load_we) begin
                mem_wdata = load_wdata;
            end
        end
    end

    always_comb begin
        rd_owner_nxt = OWN_NONE;
        if (fetch_gnt && !fetch_bad) begin
            rd_owner_nxt = OWN_FETCH;
        end else if (load_gnt && !load_we && !load_bad) begin
            rd_owner_nxt = OWN_LOAD;
        end
    end

    // Response stage (p1): remembers who owns the RAM read so the data can be steered back.
    // A faulting read answers with a NOP; a faulting write only raises the fault pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_owner_p1  <= OWN_NONE;
            fetch_nop_p1 <= 1'b0;
            load_nop_p1  <= 1'b0;
            load_flt_p1  <= 1'b0;
        end else begin
            rd_owner_p1  <= rd_owner_nxt;
            fetch_nop_p1 <= fetch_gnt && fetch_bad;
            load_nop_p1  <= load_gnt && load_bad && !load_we;
            load_flt_p1  <= load_gnt && load_bad;
        end
    end

    assign fetch_rvalid = !reset && ((rd_owner_p1 == OWN_FETCH) || fetch_nop_p1);
    assign load_rvalid  = !reset && ((rd_owner_p1 == OWN_LOAD) || load_nop_p1);

    always_comb begin
        fetch_rdata = fetch_hold_p1;
        if (fetch_rvalid) begin
            fetch_rdata = fetch_nop_p1 ? NOP_INSTR : mem_rdata;
        end
        load_rdata = load_hold_p1;
        if (load_rvalid) begin
            load_rdata = load_nop_p1 ? NOP_INSTR : mem_rdata;
        end
    end

    // Read data is held between responses and cleared by reset so outputs start at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_hold_p1 <= '0;
            load_hold_p1  <= '0;
        end else begin
            if (fetch_rvalid) begin
                fetch_hold_p1 <= fetch_rdata;
            end
            if (load_rvalid) begin
                load_hold_p1 <= load_rdata;
            end
        end
    end

`ifdef IMEM_ADDR_CHECK_EN
    assign fetch_fault = !reset && fetch_nop_p1;
    assign load_fault  = !reset && load_flt_p1;
`endif

endmodule
